pc_fetch_predictor: RTL and testbench

- Parametrised successor to the plain PC register: holds the fetch PC and produces the next PC every cycle.
- Next PC comes from a direct-mapped BTB plus a gshare pattern history table of 2-bit saturating counters, indexed by fetch PC XOR global history register (GHR).
- Sits at the IF stage. Takes stall via pc_write, and takes resolution/redirect from EX.

---
 rtl/pc_fetch_predictor.sv | 135 +++++++++++++
 tb/tb_pc_fetch_predictor.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_predictor.sv
// Fetch PC register with next-PC prediction from a direct-mapped BTB and a
// gshare table of 2-bit saturating counters indexed by PC XOR global history.
module pc_fetch_predictor #(
    parameter int unsigned     XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_PC     = '0,
    parameter int unsigned     BTB_IDX_BITS = 5,
    parameter int unsigned     GHR_BITS     = 5
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                pc_write,
    output logic [XLEN-1:0]     current_pc,
    output logic                pred_taken,
    output logic [XLEN-1:0]     pred_next_pc,
    output logic [GHR_BITS-1:0] fetch_ghr,
    input  logic                upd_valid,
    input  logic [XLEN-1:0]     upd_pc,
    input  logic                upd_is_branch,
    input  logic                upd_taken,
    input  logic [XLEN-1:0]     upd_target,
    input  logic [GHR_BITS-1:0] upd_ghr,
    input  logic                upd_mispredict,
    input  logic [XLEN-1:0]     upd_correct_pc
);

    localparam int unsigned BTB_ENTRIES = 1 << BTB_IDX_BITS;
    localparam int unsigned PHT_ENTRIES = 1 << GHR_BITS;
    localparam int unsigned TAG_BITS    = XLEN - BTB_IDX_BITS - 2;

    logic [XLEN-1:0]     pc_reg;
    logic [GHR_BITS-1:0] ghr_reg;

    logic [BTB_ENTRIES-1:0] btb_valid;
    logic [BTB_ENTRIES-1:0] btb_jump;
    logic [TAG_BITS-1:0]    btb_tag_reg    [BTB_ENTRIES];
    logic [XLEN-1:0]        btb_target_reg [BTB_ENTRIES];
    logic [PHT_ENTRIES-1:0][1:0] pht_bits;

    // Lookup side
    logic [BTB_IDX_BITS-1:0] bidx;
    logic [TAG_BITS-1:0]     tag;
    logic [GHR_BITS-1:0]     pidx;
    logic                    hit;

    assign bidx = pc_reg[BTB_IDX_BITS+1:2];
    assign tag  = pc_reg[XLEN-1:BTB_IDX_BITS+2];
    assign pidx = pc_reg[GHR_BITS+1:2] ^ ghr_reg;
    assign hit  = btb_valid[bidx] && (btb_tag_reg[bidx] == tag);

    assign pred_taken   = hit && (btb_jump[bidx] || pht_bits[pidx][1]);
    assign pred_next_pc = pred_taken ? btb_target_reg[bidx] : pc_reg + XLEN'(4);
    assign current_pc   = pc_reg;
    assign fetch_ghr    = ghr_reg;

    // Update side
    logic [BTB_IDX_BITS-1:0] upd_bidx;
    logic [TAG_BITS-1:0]     upd_tag;
    logic [GHR_BITS-1:0]     upd_pidx;
    logic                    pht_we;
    logic                    btb_we;
    logic [1:0]              upd_cnt;
    logic [1:0]              pht_next;
    logic                    unused_ok;

    assign upd_bidx  = upd_pc[BTB_IDX_BITS+1:2];
    assign upd_tag   = upd_pc[XLEN-1:BTB_IDX_BITS+2];
    assign upd_pidx  = upd_pc[GHR_BITS+1:2] ^ upd_ghr;
    assign pht_we    = upd_valid && upd_is_branch;
    assign btb_we    = upd_valid && upd_taken;
    assign upd_cnt   = pht_bits[upd_pidx];
    assign unused_ok = &{1'b0, upd_pc[1:0]};

    always_comb begin
        pht_next = upd_cnt;
        if (upd_taken) begin
            if (upd_cnt != 2'b11) pht_next = upd_cnt + 2'd1;
        end else begin
            if (upd_cnt != 2'b00) pht_next = upd_cnt - 2'd1;
        end
    end

    // A redirect from EX wins over a stall; history only moves on resolved branches.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_reg  <= RESET_PC;
            ghr_reg <= '0;
        end else begin
            if (upd_valid && upd_mispredict)
                pc_reg <= upd_correct_pc;
            else if (pc_write)
                pc_reg <= pred_next_pc;
            if (pht_we)
                ghr_reg <= {upd_ghr[GHR_BITS-2:0], upd_taken};
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < PHT_ENTRIES; gi++) begin : g_pht
            logic [1:0] cnt_reg;
            always_ff @(posedge clk or negedge reset) begin
                if (!reset)
                    cnt_reg <= 2'b01;
                else if (pht_we && (upd_pidx == GHR_BITS'(gi)))
                    cnt_reg <= pht_next;
            end
            assign pht_bits[gi] = cnt_reg;
        end

        for (gi = 0; gi < BTB_ENTRIES; gi++) begin : g_btb
            logic valid_reg;
            logic jump_reg;
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    valid_reg <= 1'b0;
                    jump_reg  <= 1'b0;
                end else if (btb_we && (upd_bidx == BTB_IDX_BITS'(gi))) begin
                    valid_reg <= 1'b1;
                    jump_reg  <= ~upd_is_branch;
                end
            end
            assign btb_valid[gi] = valid_reg;
            assign btb_jump[gi]  = jump_reg;
        end
    endgenerate

    // Tag/target storage needs no reset: entries are qualified by btb_valid.
    always_ff @(posedge clk) begin
        if (btb_we) begin
            btb_tag_reg[upd_bidx]    <= upd_tag;
            btb_target_reg[upd_bidx] <= upd_target;
        end
    end

endmodule

// File: tb/tb_pc_fetch_predictor.sv
// Scoreboard bench for pc_fetch_predictor: a reference model pushes the
// expected post-edge outputs, which are popped and compared after each edge.
module tb_pc_fetch_predictor;

    logic        clk;
    logic        reset;
    logic        pc_write;
    logic [31:0] current_pc;
    logic        pred_taken;
    logic [31:0] pred_next_pc;
    logic [4:0]  fetch_ghr;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_is_branch;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic [4:0]  upd_ghr;
    logic        upd_mispredict;
    logic [31:0] upd_correct_pc;

    pc_fetch_predictor #(
        .XLEN(32), .RESET_PC(32'h0), .BTB_IDX_BITS(5), .GHR_BITS(5)
    ) dut (
        .clk(clk), .reset(reset), .pc_write(pc_write),
        .current_pc(current_pc), .pred_taken(pred_taken),
        .pred_next_pc(pred_next_pc), .fetch_ghr(fetch_ghr),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_is_branch(upd_is_branch),
        .upd_taken(upd_taken), .upd_target(upd_target), .upd_ghr(upd_ghr),
        .upd_mispredict(upd_mispredict), .upd_correct_pc(upd_correct_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int n_txn    = 0;

    task automatic check_value(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Reference model state
    logic [31:0] m_pc;
    logic [4:0]  m_ghr;
    bit          m_valid [32];
    bit          m_jump  [32];
    logic [24:0] m_tag   [32];
    logic [31:0] m_tgt   [32];
    logic [1:0]  m_pht   [32];

    typedef struct {
        string       tag;
        logic [31:0] pc;
        logic        taken;
        logic [31:0] npc;
        logic [4:0]  ghr;
    } exp_t;
    exp_t sb_q[$];

    task automatic m_reset();
        m_pc  = 32'h0;
        m_ghr = 5'd0;
        for (int i = 0; i < 32; i++) begin
            m_valid[i] = 0;
            m_jump[i]  = 0;
            m_pht[i]   = 2'b01;
        end
    endtask

    task automatic m_lookup(output logic t, output logic [31:0] npc);
        int b;
        int p;
        bit h;
        b = int'(m_pc[6:2]);
        p = int'(m_pc[6:2] ^ m_ghr);
        h = m_valid[b] && (m_tag[b] == m_pc[31:7]);
        t = h && (m_jump[b] || m_pht[p][1]);
        npc = t ? m_tgt[b] : m_pc + 32'd4;
    endtask

    task automatic do_cycle(input string tag, input bit pw, input bit uv, input bit ub,
                            input bit ut, input logic [31:0] upc, input logic [31:0] utgt,
                            input logic [4:0] ughr, input bit umis, input logic [31:0] ucorr);
        logic        t0, t1;
        logic [31:0] npc0, npc1, nxt;
        exp_t        e;
        int          p, b;
        pc_write = pw; upd_valid = uv; upd_is_branch = ub; upd_taken = ut;
        upd_pc = upc; upd_target = utgt; upd_ghr = ughr;
        upd_mispredict = umis; upd_correct_pc = ucorr;
        m_lookup(t0, npc0);
        nxt = m_pc;
        if (uv && umis) nxt = ucorr;
        else if (pw) nxt = npc0;
        if (uv && ub) begin
            p = int'(upc[6:2] ^ ughr);
            if (ut) begin
                if (m_pht[p] != 2'b11) m_pht[p] = m_pht[p] + 2'd1;
            end else begin
                if (m_pht[p] != 2'b00) m_pht[p] = m_pht[p] - 2'd1;
            end
            m_ghr = {ughr[3:0], ut};
        end
        if (uv && ut) begin
            b = int'(upc[6:2]);
            m_valid[b] = 1;
            m_jump[b]  = !ub;
            m_tag[b]   = upc[31:7];
            m_tgt[b]   = utgt;
        end
        m_pc = nxt;
        m_lookup(t1, npc1);
        sb_q.push_back('{tag, m_pc, t1, npc1, m_ghr});
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        check_value({e.tag, ".pc"},    64'(current_pc),   64'(e.pc));
        check_value({e.tag, ".taken"}, 64'(pred_taken),   64'(e.taken));
        check_value({e.tag, ".npc"},   64'(pred_next_pc), 64'(e.npc));
        check_value({e.tag, ".ghr"},   64'(fetch_ghr),    64'(e.ghr));
        n_txn++;
        $display("txn %0d %s: pc=0x%0h taken=%0b next=0x%0h ghr=%05b",
                 n_txn, e.tag, current_pc, pred_taken, pred_next_pc, fetch_ghr);
    endtask

    task automatic idle(input string tag, input bit pw);
        do_cycle(tag, pw, 0, 0, 0, 32'h0, 32'h0, 5'd0, 0, 32'h0);
    endtask

    // Pure redirect: valid, not a branch, not taken, so no table or history writes.
    task automatic redirect(input string tag, input logic [31:0] pc);
        do_cycle(tag, 0, 1, 0, 0, 32'h0, 32'h0, 5'd0, 1, pc);
    endtask

    task automatic resolve(input string tag, input bit br, input bit tk,
                           input logic [31:0] upc, input logic [31:0] tgt, input logic [4:0] gh);
        do_cycle(tag, 0, 1, br, tk, upc, tgt, gh, 0, 32'h0);
    endtask

    initial begin
        reset = 1'b0; pc_write = 1'b0; upd_valid = 1'b0; upd_pc = '0;
        upd_is_branch = 1'b0; upd_taken = 1'b0; upd_target = '0; upd_ghr = '0;
        upd_mispredict = 1'b0; upd_correct_pc = '0;
        m_reset();
        repeat (3) @(posedge clk);
        #1;
        check_value("rst.pc",    64'(current_pc),   64'h0);
        check_value("rst.taken", 64'(pred_taken),   64'h0);
        check_value("rst.npc",   64'(pred_next_pc), 64'h4);
        check_value("rst.ghr",   64'(fetch_ghr),    64'h0);
        reset = 1'b1;

        for (int i = 0; i < 4; i++) idle("seq", 1);
        check_value("seq_end.pc", 64'(current_pc), 64'h10);

        idle("stall", 0);
        idle("stall", 0);
        check_value("stall.pc", 64'(current_pc), 64'h10);
        redirect("redir", 32'h200);
        check_value("redir.pc", 64'(current_pc), 64'h200);

        resolve("jal_upd", 0, 1, 32'h40, 32'h100, 5'd0);
        redirect("to_jal", 32'h40);
        check_value("jal.taken", 64'(pred_taken),   64'h1);
        check_value("jal.npc",   64'(pred_next_pc), 64'h100);
        idle("jal_follow", 1);
        check_value("jal_follow.pc",  64'(current_pc), 64'h100);
        check_value("jal_follow.ghr", 64'(fetch_ghr),  64'h0);

        // 0x60 with history 0 trains counter 0x18, leaving 0x20's counter 8 at 10.
        resolve("gs_t", 1, 1, 32'h20, 32'h80, 5'd0);
        check_value("gs_t.ghr", 64'(fetch_ghr), 64'h1);
        resolve("gs_nt", 1, 0, 32'h60, 32'h0, 5'd0);
        redirect("to_br", 32'h20);
        check_value("gs.taken", 64'(pred_taken),   64'h1);
        check_value("gs.npc",   64'(pred_next_pc), 64'h80);
        idle("gs_follow", 1);
        check_value("gs_follow.pc", 64'(current_pc), 64'h80);

        for (int i = 0; i < 3; i++) resolve("sat_t", 1, 1, 32'h30, 32'h300, 5'd0);
        resolve("sat_nt1", 1, 0, 32'h30, 32'h0, 5'd0);
        redirect("to_sat", 32'h30);
        check_value("sat_hi.taken", 64'(pred_taken),   64'h1);
        check_value("sat_hi.npc",   64'(pred_next_pc), 64'h300);
        resolve("sat_nt2", 1, 0, 32'h30, 32'h0, 5'd0);
        check_value("sat_lo.taken", 64'(pred_taken),   64'h0);
        check_value("sat_lo.npc",   64'(pred_next_pc), 64'h34);

        // Asynchronous reset between edges with a redirect pending.
        redirect("pre_rst", 32'h40);
        pc_write = 1'b1; upd_valid = 1'b1; upd_mispredict = 1'b1; upd_correct_pc = 32'h500;
        #2;
        reset = 1'b0;
        #1;
        m_reset();
        check_value("arst.pc",    64'(current_pc), 64'h0);
        check_value("arst.taken", 64'(pred_taken), 64'h0);
        check_value("arst.ghr",   64'(fetch_ghr),  64'h0);
        @(posedge clk);
        #1;
        check_value("arst_hold.pc", 64'(current_pc), 64'h0);
        reset = 1'b1;
        redirect("post_rst", 32'h40);
        check_value("post_rst.taken", 64'(pred_taken),   64'h0);
        check_value("post_rst.npc",   64'(pred_next_pc), 64'h44);
        idle("post_follow", 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
